// File: rtl/lidar_scan_sequencer_if.sv
// -----------------------------------------------------------------------------
// lidar_scan_sequencer_if
//   Byte-level link between the LiDAR scan sequencer and the board UART blocks.
//   One shared TX front-end (steered by tx_sel) and two RX byte streams.
//
//   tx_data  [7:0]  byte to transmit                        (sequencer -> UART TX)
//   tx_sel          0 = LiDAR_TX_1, 1 = LiDAR_TX_2           (sequencer -> UART TX)
//   tx_trmt         1-cycle pulse: start sending tx_data     (sequencer -> UART TX)
//   tx_done         1-cycle pulse: byte finished             (UART TX -> sequencer)
//   rx_rdy   [1:0]  per-channel 1-cycle byte-valid pulse     (UART RX -> sequencer)
//   rx_data1 [7:0]  byte from LiDAR_RX_1                     (UART RX -> sequencer)
//   rx_data2 [7:0]  byte from LiDAR_RX_2                     (UART RX -> sequencer)
//
//   master: the sequencer side.  slave: the UART / LiDAR side.
// -----------------------------------------------------------------------------
interface lidar_scan_sequencer_if;
  logic [7:0] tx_data;
  logic       tx_sel;
  logic       tx_trmt;
  logic       tx_done;
  logic [1:0] rx_rdy;
  logic [7:0] rx_data1;
  logic [7:0] rx_data2;

  modport master (
    output tx_data, tx_sel, tx_trmt,
    input  tx_done, rx_rdy, rx_data1, rx_data2
  );

  modport slave (
    input  tx_data, tx_sel, tx_trmt,
    output tx_done, rx_rdy, rx_data1, rx_data2
  );
endinterface

// File: rtl/lidar_scan_sequencer.sv
// -----------------------------------------------------------------------------
// lidar_scan_sequencer
//   Brings up and shuts down the two RPLIDAR units. For each channel it sends
//   STOP (A5 25), waits a settle time, sends SCAN (A5 20) and then looks for the
//   7-byte scan response descriptor (A5 5A 05 00 00 40 81) on that channel's RX.
//   A missing descriptor is retried up to MAX_RETRY attempts, after which the
//   channel is flagged as faulted. A stop request shuts both units down.
//
//   clk       system clock
//   rst_n     asynchronous active-low reset
//   start     1-cycle pulse: begin bring-up (honoured only in IDLE)
//   stop      1-cycle pulse: abort / shut down (honoured in busy states and RUN)
//   lidar     master side of the UART byte link (see lidar_scan_sequencer_if)
//   busy      sequence in progress (any state except IDLE and RUN)
//   scanning  bit ch set: channel ch returned a valid descriptor
//   fault     bit ch set: channel ch exhausted its descriptor attempts
// -----------------------------------------------------------------------------
module lidar_scan_sequencer #(
  parameter int SETTLE_CYCLES  = 100_000,
  parameter int TIMEOUT_CYCLES = 5_000_000,
  parameter int MAX_RETRY      = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  stop,
  lidar_scan_sequencer_if.master lidar,
  output logic                  busy,
  output logic [1:0]            scanning,
  output logic [1:0]            fault
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_TX_STOP   = 3'd1;
  localparam logic [2:0] S_SETTLE    = 3'd2;
  localparam logic [2:0] S_TX_SCAN   = 3'd3;
  localparam logic [2:0] S_WAIT_DESC = 3'd4;
  localparam logic [2:0] S_NEXT_CH   = 3'd5;
  localparam logic [2:0] S_RUN       = 3'd6;
  localparam logic [2:0] S_SHUTDOWN  = 3'd7;

  localparam logic [22:0] SETTLE_LAST  = 23'(SETTLE_CYCLES - 1);
  localparam logic [22:0] TIMEOUT_LAST = 23'(TIMEOUT_CYCLES - 1);

  function automatic logic [7:0] desc_byte(input logic [2:0] idx);
    case (idx)
      3'd0:    return 8'hA5;
      3'd1:    return 8'h5A;
      3'd2:    return 8'h05;
      3'd3:    return 8'h00;
      3'd4:    return 8'h00;
      3'd5:    return 8'h40;
      3'd6:    return 8'h81;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [22:0] sat_inc(input logic [22:0] v);
    return (&v) ? v : v + 23'd1;
  endfunction

  logic [2:0]  state_q,    state_d;
  logic        ch_q,       ch_d;
  logic [1:0]  retry_q,    retry_d;
  logic [2:0]  idx_q,      idx_d;
  logic [22:0] timer_q,    timer_d;
  logic        second_q,   second_d;   // byte in flight is the 2nd of its command
  logic        wait_q,     wait_d;     // a byte is in flight, waiting for tx_done
  logic        abort_q,    abort_d;    // stop seen while a byte was in flight
  logic [1:0]  scanning_q, scanning_d;
  logic [1:0]  fault_q,    fault_d;
  logic        trmt_q,     trmt_d;
  logic [7:0]  data_q,     data_d;
  logic        sel_q,      sel_d;

  logic        tx_fin;
  logic        rx_hit;
  logic [7:0]  rx_byte;
  logic [2:0]  idx_nxt;
  logic        launch;     // send first byte (A5) of a new command
  logic        launch_ch;
  logic        send2;      // send second byte of the current command
  logic        shut;       // enter SHUTDOWN

  assign tx_fin  = wait_q & lidar.tx_done;
  assign rx_hit  = lidar.rx_rdy[ch_q];
  assign rx_byte = ch_q ? lidar.rx_data2 : lidar.rx_data1;

  always_comb begin
    state_d    = state_q;
    ch_d       = ch_q;
    retry_d    = retry_q;
    idx_d      = idx_q;
    timer_d    = timer_q;
    second_d   = second_q;
    wait_d     = wait_q;
    abort_d    = abort_q;
    scanning_d = scanning_q;
    fault_d    = fault_q;
    trmt_d     = 1'b0;
    data_d     = data_q;
    sel_d      = sel_q;
    launch     = 1'b0;
    launch_ch  = ch_q;
    send2      = 1'b0;
    shut       = 1'b0;

    // Descriptor matcher: a mismatching A5 may itself be the start of a new
    // descriptor, so it restarts the match at index 1 rather than 0.
    idx_nxt = idx_q;
    if (rx_hit) begin
      if (rx_byte == desc_byte(idx_q)) idx_nxt = idx_q + 3'd1;
      else if (rx_byte == 8'hA5)       idx_nxt = 3'd1;
      else                             idx_nxt = 3'd0;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          scanning_d = 2'b00;
          fault_d    = 2'b00;
          ch_d       = 1'b0;
          retry_d    = 2'd0;
          state_d    = S_TX_STOP;
          launch     = 1'b1;
          launch_ch  = 1'b0;
        end
      end

      S_TX_STOP, S_TX_SCAN: begin
        if (tx_fin) begin
          wait_d = 1'b0;
          if (abort_q || stop) begin
            shut = 1'b1;
          end else if (!second_q) begin
            send2 = 1'b1;
          end else if (state_q == S_TX_STOP) begin
            state_d = S_SETTLE;
            timer_d = 23'd0;
          end else begin
            state_d = S_WAIT_DESC;
            timer_d = 23'd0;
            idx_d   = 3'd0;
          end
        end else if (stop) begin
          // Let the in-flight byte finish before shutting down.
          if (wait_q) abort_d = 1'b1;
          else        shut    = 1'b1;
        end
      end

      S_SETTLE: begin
        if (stop) begin
          shut = 1'b1;
        end else if (timer_q == SETTLE_LAST) begin
          state_d = S_TX_SCAN;
          launch  = 1'b1;
        end else begin
          timer_d = sat_inc(timer_q);
        end
      end

      S_WAIT_DESC: begin
        if (stop) begin
          shut = 1'b1;
        end else if (rx_hit && idx_nxt == 3'd7) begin
          // A completing byte takes priority over a simultaneous timeout.
          idx_d            = idx_nxt;
          scanning_d[ch_q] = 1'b1;
          state_d          = S_NEXT_CH;
        end else if (timer_q == TIMEOUT_LAST) begin
          retry_d = retry_q + 2'd1;
          if ((int'(retry_q) + 1) < MAX_RETRY) begin
            state_d = S_TX_STOP;
            launch  = 1'b1;
          end else begin
            fault_d[ch_q] = 1'b1;
            state_d       = S_NEXT_CH;
          end
        end else begin
          idx_d   = idx_nxt;
          timer_d = sat_inc(timer_q);
        end
      end

      S_NEXT_CH: begin
        if (stop) begin
          shut = 1'b1;
        end else if (!ch_q) begin
          ch_d      = 1'b1;
          retry_d   = 2'd0;
          state_d   = S_TX_STOP;
          launch    = 1'b1;
          launch_ch = 1'b1;
        end else begin
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        if (stop) shut = 1'b1;
      end

      S_SHUTDOWN: begin
        // STOP to channel 0, then channel 1; start/stop are ignored here.
        if (tx_fin) begin
          wait_d = 1'b0;
          if (!second_q) begin
            send2 = 1'b1;
          end else if (!ch_q) begin
            ch_d      = 1'b1;
            launch    = 1'b1;
            launch_ch = 1'b1;
          end else begin
            scanning_d = 2'b00;
            ch_d       = 1'b0;
            state_d    = S_IDLE;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    if (shut) begin
      state_d   = S_SHUTDOWN;
      ch_d      = 1'b0;
      abort_d   = 1'b0;
      launch    = 1'b1;
      launch_ch = 1'b0;
    end

    if (launch) begin
      trmt_d   = 1'b1;
      data_d   = 8'hA5;
      sel_d    = launch_ch;
      wait_d   = 1'b1;
      second_d = 1'b0;
    end else if (send2) begin
      trmt_d   = 1'b1;
      data_d   = (state_q == S_TX_SCAN) ? 8'h20 : 8'h25;
      wait_d   = 1'b1;
      second_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      ch_q       <= 1'b0;
      retry_q    <= 2'd0;
      idx_q      <= 3'd0;
      timer_q    <= 23'd0;
      second_q   <= 1'b0;
      wait_q     <= 1'b0;
      abort_q    <= 1'b0;
      scanning_q <= 2'b00;
      fault_q    <= 2'b00;
      trmt_q     <= 1'b0;
      data_q     <= 8'h00;
      sel_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ch_q       <= ch_d;
      retry_q    <= retry_d;
      idx_q      <= idx_d;
      timer_q    <= timer_d;
      second_q   <= second_d;
      wait_q     <= wait_d;
      abort_q    <= abort_d;
      scanning_q <= scanning_d;
      fault_q    <= fault_d;
      trmt_q     <= trmt_d;
      data_q     <= data_d;
      sel_q      <= sel_d;
    end
  end

  assign lidar.tx_trmt = trmt_q;
  assign lidar.tx_data = data_q;
  assign lidar.tx_sel  = sel_q;
  assign busy          = (state_q != S_IDLE) && (state_q != S_RUN);
  assign scanning      = scanning_q;
  assign fault         = fault_q;

endmodule

// File: tb/tb_lidar_scan_sequencer.sv
`timescale 1ns/1ps
module tb_lidar_scan_sequencer;

  localparam int SETTLE  = 10;
  localparam int TIMEOUT = 200;
  localparam int MAXR    = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       busy;
  logic [1:0] scanning;
  logic [1:0] fault;

  lidar_scan_sequencer_if lif();

  lidar_scan_sequencer #(
    .SETTLE_CYCLES (SETTLE),
    .TIMEOUT_CYCLES(TIMEOUT),
    .MAX_RETRY     (MAXR)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .stop    (stop),
    .lidar   (lif),
    .busy    (busy),
    .scanning(scanning),
    .fault   (fault)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Observed TX stream and expected TX stream, entries {sel, data}.
  logic [8:0] log_q[$];
  logic [8:0] exp_q[$];

  // UART TX model state
  int         done_lat = 20;
  int         pending  = 0;
  logic       cur_sel  = 1'b0;
  logic [7:0] cur_data = 8'h00;

  // LiDAR RX model state: bytes each unit answers to a SCAN with
  logic [7:0] resp0[$];
  logic [7:0] resp1[$];
  bit         resp_go   = 1'b0;
  bit         resp_ch   = 1'b0;
  bit         garbage_en = 1'b0;
  bit         garb_rand  = 1'b0;
  logic [7:0] rq[$];
  bit         rch;

  logic [7:0] desc_b [0:6] = '{8'hA5, 8'h5A, 8'h05, 8'h00, 8'h00, 8'h40, 8'h81};

  // UART TX: acknowledge every tx_trmt with tx_done done_lat cycles later.
  initial begin
    lif.tx_done = 1'b0;
    forever begin
      @(negedge clk);
      lif.tx_done = 1'b0;
      if (lif.tx_trmt) begin
        checks++;
        if (pending != 0) begin
          failures++;
          $display("FAIL tx_overlap: tx_trmt with byte still pending=%0d, required pending=0", pending);
        end
        log_q.push_back({lif.tx_sel, lif.tx_data});
        cur_sel  = lif.tx_sel;
        cur_data = lif.tx_data;
        pending  = done_lat;
      end else if (pending > 0) begin
        pending--;
        if (pending == 0) begin
          checks++;
          if (lif.tx_sel !== cur_sel) begin
            failures++;
            $display("FAIL tx_sel_stable: tx_sel=%0b at tx_done, required %0b", lif.tx_sel, cur_sel);
          end
          lif.tx_done = 1'b1;
          if (cur_data == 8'h20) begin
            resp_ch = cur_sel;
            resp_go = 1'b1;
          end
        end
      end
    end
  end

  // LiDAR RX: after each SCAN, the addressed unit replies with its byte list;
  // optionally the other unit chatters at the same time.
  initial begin
    lif.rx_rdy   = 2'b00;
    lif.rx_data1 = 8'h00;
    lif.rx_data2 = 8'h00;
    forever begin
      @(negedge clk);
      lif.rx_rdy = 2'b00;
      if (resp_go) begin
        resp_go = 1'b0;
        rch     = resp_ch;
        rq      = rch ? resp1 : resp0;
        repeat (3) @(negedge clk);
        foreach (rq[i]) begin
          if (garbage_en && ($urandom_range(0, 1) == 1)) begin
            if (rch) lif.rx_data1 = garb_rand ? 8'($urandom_range(0, 127)) : 8'h00;
            else     lif.rx_data2 = garb_rand ? 8'($urandom_range(0, 127)) : 8'h00;
            lif.rx_rdy = rch ? 2'b01 : 2'b10;
            @(negedge clk);
            lif.rx_rdy = 2'b00;
          end
          if (rch) lif.rx_data2 = rq[i];
          else     lif.rx_data1 = rq[i];
          lif.rx_rdy = rch ? 2'b10 : 2'b01;
          @(negedge clk);
          lif.rx_rdy = 2'b00;
          repeat ($urandom_range(0, 2)) @(negedge clk);
        end
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  // ---------------------------------------------------------------- helpers
  // kind: 0 silent, 1 descriptor, 2 partial descriptor only,
  //       3 junk then descriptor, 4 A5 then descriptor
  task automatic set_resp(input bit ch, input int kind);
    logic [7:0] q[$];
    q = {};
    if (kind == 2) for (int i = 0; i < 3; i++) q.push_back(desc_b[i]);
    if (kind == 3) repeat ($urandom_range(1, 3)) q.push_back(8'($urandom_range(0, 127)));
    if (kind == 4) q.push_back(8'hA5);
    if (kind == 1 || kind == 3 || kind == 4) for (int i = 0; i < 7; i++) q.push_back(desc_b[i]);
    if (ch) resp1 = q;
    else    resp0 = q;
  endtask

  // Expected TX stream for a bring-up: per channel, one STOP+SCAN pair per
  // descriptor attempt (1 if the unit answers, MAX_RETRY if it stays silent).
  task automatic build_startup(input bit [1:0] ok);
    exp_q = {};
    for (int c = 0; c < 2; c++) begin
      int  n;
      logic s;
      s = c[0];
      n = ok[c] ? 1 : MAXR;
      for (int a = 0; a < n; a++) begin
        exp_q.push_back({s, 8'hA5});
        exp_q.push_back({s, 8'h25});
        exp_q.push_back({s, 8'hA5});
        exp_q.push_back({s, 8'h20});
      end
    end
  endtask

  task automatic push_shutdown();
    exp_q.push_back({1'b0, 8'hA5});
    exp_q.push_back({1'b0, 8'h25});
    exp_q.push_back({1'b1, 8'hA5});
    exp_q.push_back({1'b1, 8'h25});
  endtask

  function automatic bit logs_equal();
    if (log_q.size() != exp_q.size()) return 1'b0;
    foreach (exp_q[i]) if (log_q[i] !== exp_q[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic string fmt(input logic [8:0] q[$]);
    string s;
    s = "";
    foreach (q[i]) if (i < 40) s = {s, $sformatf("%0d:%h ", q[i][8], q[i][7:0])};
    return s;
  endfunction

  // Wait until the DUT is out of its busy states and the TX link is quiet.
  task automatic wait_settled(input int budget, output bit ok);
    int quiet;
    quiet = 0;
    ok    = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy && pending == 0 && !lif.tx_trmt) quiet++;
      else quiet = 0;
      if (quiet >= 5) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic pulse_stop();
    @(negedge clk); stop = 1'b1;
    @(negedge clk); stop = 1'b0;
  endtask

  task automatic go_idle();
    bit ok;
    pulse_stop();
    wait_settled(3000, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL go_idle: busy=%0b pending=%0d after budget, required idle", busy, pending);
    end
  endtask

  // ------------------------------------------------------------------ tests
  task automatic test_reset();
    bit ok;
    int n;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({lif.tx_trmt, lif.tx_data, lif.tx_sel, busy, scanning, fault} !== 15'd0) begin
      failures++;
      $display("FAIL reset_outputs: trmt=%0b data=%h sel=%0b busy=%0b scan=%b fault=%b, required all 0",
               lif.tx_trmt, lif.tx_data, lif.tx_sel, busy, scanning, fault);
    end
    rst_n = 1'b1;

    // Reset asserted while waiting for a descriptor that never comes.
    done_lat = 5;
    set_resp(0, 0);
    set_resp(1, 0);
    pulse_start();
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (log_q.size() >= 4 && pending == 0) begin ok = 1'b1; break; end
    end
    repeat (20) @(negedge clk);
    checks++;
    if (!ok || busy !== 1'b1) begin
      failures++;
      $display("FAIL reset_reach_wait: ok=%0b busy=%0b, required ok=1 busy=1", ok, busy);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({lif.tx_trmt, lif.tx_data, lif.tx_sel, busy, scanning, fault} !== 15'd0) begin
      failures++;
      $display("FAIL reset_async: trmt=%0b data=%h sel=%0b busy=%0b scan=%b fault=%b, required all 0",
               lif.tx_trmt, lif.tx_data, lif.tx_sel, busy, scanning, fault);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    n = log_q.size();
    repeat (20) @(negedge clk);
    checks++;
    if (log_q.size() != n || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle: new tx bytes=%0d busy=%0b, required 0 bytes busy=0", log_q.size() - n, busy);
    end
  endtask

  task automatic test_normal();
    bit ok;
    wait_settled(200, ok);
    log_q = {};
    done_lat = 20;
    garbage_en = 1'b0;
    set_resp(0, 1);
    set_resp(1, 1);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    checks++;
    if (lif.tx_trmt !== 1'b1 || lif.tx_data !== 8'hA5 || lif.tx_sel !== 1'b0) begin
      failures++;
      $display("FAIL start_latency: trmt=%0b data=%h sel=%0b, required 1 A5 0", lif.tx_trmt, lif.tx_data, lif.tx_sel);
    end
    wait_settled(5000, ok);
    build_startup(2'b11);
    checks++;
    if (!ok || !logs_equal()) begin
      failures++;
      $display("FAIL normal_log: got %s required %s", fmt(log_q), fmt(exp_q));
    end
    checks++;
    if (scanning !== 2'b11 || fault !== 2'b00 || busy !== 1'b0) begin
      failures++;
      $display("FAIL normal_status: scan=%b fault=%b busy=%0b, required 11 00 0", scanning, fault, busy);
    end
    go_idle();
  endtask

  task automatic test_timeout();
    bit ok;
    int nscan;
    log_q = {};
    done_lat = 5;
    set_resp(0, 0);
    set_resp(1, 1);
    pulse_start();
    wait_settled(5000, ok);
    build_startup(2'b10);
    nscan = 0;
    foreach (log_q[i]) if (log_q[i] == {1'b0, 8'h20}) nscan++;
    checks++;
    if (nscan != MAXR) begin
      failures++;
      $display("FAIL timeout_scan_count: %0d SCANs on sel 0, required %0d", nscan, MAXR);
    end
    checks++;
    if (!ok || !logs_equal()) begin
      failures++;
      $display("FAIL timeout_log: got %s required %s", fmt(log_q), fmt(exp_q));
    end
    checks++;
    if (scanning !== 2'b10 || fault !== 2'b01) begin
      failures++;
      $display("FAIL timeout_status: scan=%b fault=%b, required 10 01", scanning, fault);
    end
    go_idle();
  endtask

  task automatic test_cross_channel();
    bit ok;
    log_q = {};
    done_lat = 7;
    garbage_en = 1'b1;
    garb_rand  = 1'b0;
    set_resp(0, 1);
    set_resp(1, 4);
    pulse_start();
    wait_settled(5000, ok);
    build_startup(2'b11);
    checks++;
    if (!ok || !logs_equal()) begin
      failures++;
      $display("FAIL cross_log: got %s required %s", fmt(log_q), fmt(exp_q));
    end
    checks++;
    if (scanning !== 2'b11 || fault !== 2'b00) begin
      failures++;
      $display("FAIL cross_status: scan=%b fault=%b, required 11 00", scanning, fault);
    end
    garbage_en = 1'b0;
  endtask

  task automatic test_stop_run();
    bit ok;
    log_q = {};
    pulse_start();
    repeat (10) @(negedge clk);
    checks++;
    if (log_q.size() != 0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL run_start_ignored: tx bytes=%0d busy=%0b, required 0 0", log_q.size(), busy);
    end
    pulse_stop();
    wait_settled(3000, ok);
    exp_q = {};
    push_shutdown();
    checks++;
    if (!ok || !logs_equal()) begin
      failures++;
      $display("FAIL run_stop_log: got %s required %s", fmt(log_q), fmt(exp_q));
    end
    checks++;
    if (scanning !== 2'b00 || busy !== 1'b0) begin
      failures++;
      $display("FAIL run_stop_status: scan=%b busy=%0b, required 00 0", scanning, busy);
    end
    // Restart after shutdown runs the full bring-up again.
    log_q = {};
    set_resp(0, 1);
    set_resp(1, 1);
    pulse_start();
    wait_settled(5000, ok);
    build_startup(2'b11);
    checks++;
    if (!ok || !logs_equal() || scanning !== 2'b11) begin
      failures++;
      $display("FAIL restart: scan=%b got %s required %s", scanning, fmt(log_q), fmt(exp_q));
    end
    go_idle();
  endtask

  task automatic test_stop_settle();
    bit ok;
    log_q = {};
    done_lat = 4;
    set_resp(0, 1);
    set_resp(1, 1);
    pulse_start();
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (log_q.size() >= 2 && pending == 0) begin ok = 1'b1; break; end
    end
    repeat (3) @(negedge clk);
    pulse_stop();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (log_q.size() >= 3) break;
    end
    pulse_start();
    wait_settled(3000, ok);
    exp_q = {};
    exp_q.push_back({1'b0, 8'hA5});
    exp_q.push_back({1'b0, 8'h25});
    push_shutdown();
    checks++;
    if (!ok || !logs_equal()) begin
      failures++;
      $display("FAIL settle_stop_log: got %s required %s", fmt(log_q), fmt(exp_q));
    end
    checks++;
    if (scanning !== 2'b00 || fault !== 2'b00 || busy !== 1'b0) begin
      failures++;
      $display("FAIL settle_stop_status: scan=%b fault=%b busy=%0b, required 00 00 0", scanning, fault, busy);
    end
  endtask

  task automatic test_stop_inflight();
    bit ok;
    log_q = {};
    done_lat = 15;
    pulse_start();
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (log_q.size() >= 3) break;
    end
    pulse_stop();
    wait_settled(3000, ok);
    exp_q = {};
    exp_q.push_back({1'b0, 8'hA5});
    exp_q.push_back({1'b0, 8'h25});
    exp_q.push_back({1'b0, 8'hA5});
    push_shutdown();
    checks++;
    if (!ok || !logs_equal()) begin
      failures++;
      $display("FAIL inflight_stop_log: got %s required %s", fmt(log_q), fmt(exp_q));
    end
  endtask

  task automatic test_random();
    bit       ok;
    bit [1:0] good;
    for (int it = 0; it < 5; it++) begin
      good       = 2'($urandom_range(0, 3));
      done_lat   = $urandom_range(1, 25);
      garbage_en = 1'b1;
      garb_rand  = 1'b1;
      for (int c = 0; c < 2; c++)
        set_resp(c[0], good[c] ? (($urandom_range(0, 1) == 1) ? 3 : 1)
                               : (($urandom_range(0, 1) == 1) ? 2 : 0));
      log_q = {};
      pulse_start();
      wait_settled(6000, ok);
      build_startup(good);
      checks++;
      if (!ok || !logs_equal()) begin
        failures++;
        $display("FAIL rand%0d_log: good=%b got %s required %s", it, good, fmt(log_q), fmt(exp_q));
      end
      checks++;
      if (scanning !== good || fault !== ~good) begin
        failures++;
        $display("FAIL rand%0d_status: scan=%b fault=%b, required %b %b", it, scanning, fault, good, ~good);
      end
      log_q = {};
      pulse_stop();
      wait_settled(3000, ok);
      exp_q = {};
      push_shutdown();
      checks++;
      if (!ok || !logs_equal() || scanning !== 2'b00 || fault !== ~good) begin
        failures++;
        $display("FAIL rand%0d_shutdown: scan=%b fault=%b got %s required 00 %b %s",
                 it, scanning, fault, fmt(log_q), ~good, fmt(exp_q));
      end
    end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_timeout();
    test_cross_channel();
    test_stop_run();
    test_stop_settle();
    test_stop_inflight();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
